// File: rtl/fifo_port_sched.sv
// Write-port arbiter and read gate for a single FIFO instance.
// Two requesters share the write port round-robin; a shadow count drives full/empty decisions.
module fifo_port_sched #(
   parameter int unsigned B        = 3,
   parameter int unsigned W        = 2,
   parameter int unsigned AF_LEVEL = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [1:0]   req,
   input  logic [B-1:0] data0,
   input  logic [B-1:0] data1,
   output logic [1:0]   ack,
   input  logic         rd_req,
   output logic         fifo_wr,
   output logic [B-1:0] fifo_w_data,
   output logic         fifo_rd,
   output logic [W:0]   count,
   output logic         almost_full,
   output logic         full,
   output logic         empty
);

   localparam int unsigned Depth    = 2 ** W;
   localparam logic [W:0]  DepthW   = (W+1)'(Depth);
   localparam logic [W:0]  AfLevelW = (W+1)'(AF_LEVEL);

   logic [1:0]   ack_q;
   logic         fifo_wr_q;
   logic [B-1:0] wdata_q;
   logic [W:0]   count_q, count_d;
   logic         af_q;
   logic         last_q;

   logic [1:0]   elig;
   logic         space_ok;
   logic         gnt_valid;
   logic         gnt_idx;
   logic         rd_ok;

   always_comb begin
      elig      = req & ~ack_q;
      // Conservative: a write already in flight counts, a same-cycle read does not.
      space_ok  = (count_q + {{W{1'b0}}, fifo_wr_q}) < DepthW;
      gnt_valid = 1'b0;
      gnt_idx   = 1'b0;
      if (space_ok) begin
         unique case (elig)
            2'b01: begin
               gnt_valid = 1'b1;
               gnt_idx   = 1'b0;
            end
            2'b10: begin
               gnt_valid = 1'b1;
               gnt_idx   = 1'b1;
            end
            2'b11: begin
               gnt_valid = 1'b1;
               gnt_idx   = ~last_q;
            end
            default: ;
         endcase
      end
      rd_ok   = rd_req & (count_q != '0);
      count_d = count_q + {{W{1'b0}}, fifo_wr_q} - {{W{1'b0}}, rd_ok};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack_q     <= 2'b00;
         fifo_wr_q <= 1'b0;
         wdata_q   <= '0;
         count_q   <= '0;
         af_q      <= 1'b0;
         last_q    <= 1'b1;
      end else begin
         count_q   <= count_d;
         af_q      <= (count_d >= AfLevelW);
         fifo_wr_q <= gnt_valid;
         ack_q     <= 2'b00;
         if (gnt_valid) begin
            ack_q[gnt_idx] <= 1'b1;
            wdata_q        <= gnt_idx ? data1 : data0;
            last_q         <= gnt_idx;
         end
      end
   end

   assign ack         = ack_q;
   assign fifo_wr     = fifo_wr_q;
   assign fifo_w_data = wdata_q;
   assign fifo_rd     = rd_ok;
   assign count       = count_q;
   assign almost_full = af_q;
   assign full        = (count_q == DepthW);
   assign empty       = (count_q == '0);

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(count_q == DepthW && fifo_wr_q && !rd_ok))
            else $error("fifo_port_sched: shadow count overflow");
         assert (!(count_q == '0 && rd_ok))
            else $error("fifo_port_sched: shadow count underflow");
         assert (count_q <= DepthW)
            else $error("fifo_port_sched: shadow count out of range");
      end
   end
`endif

endmodule

// File: tb/tb_fifo_port_sched.sv
// Self-checking bench for fifo_port_sched: directed scenarios followed by random traffic,
// compared against a queue-based model of the FIFO and the round-robin write rules.
module tb_fifo_port_sched;

   localparam int B     = 3;
   localparam int W     = 2;
   localparam int DEPTH = 4;
   localparam int AF    = 3;

   logic         clk    = 1'b0;
   logic         reset  = 1'b1;
   logic [1:0]   req    = 2'b00;
   logic [B-1:0] data0  = '0;
   logic [B-1:0] data1  = '0;
   logic         rd_req = 1'b0;
   logic [1:0]   ack;
   logic         fifo_wr;
   logic [B-1:0] fifo_w_data;
   logic         fifo_rd;
   logic [W:0]   count;
   logic         almost_full;
   logic         full;
   logic         empty;

   fifo_port_sched #(.B(B), .W(W), .AF_LEVEL(AF)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .data0       (data0),
      .data1       (data1),
      .ack         (ack),
      .rd_req      (rd_req),
      .fifo_wr     (fifo_wr),
      .fifo_w_data (fifo_w_data),
      .fifo_rd     (fifo_rd),
      .count       (count),
      .almost_full (almost_full),
      .full        (full),
      .empty       (empty)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Model: m_q is the FIFO content, m_pend a write issued but not yet stored.
   logic [B-1:0] m_q[$];
   logic [B-1:0] d_q[$];
   bit           m_pend;
   logic [B-1:0] m_wdata;
   logic [1:0]   m_ack;
   int           m_last;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp)
         else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
         end
   endtask

   task automatic model_reset();
      m_q.delete();
      d_q.delete();
      m_pend  = 1'b0;
      m_wdata = '0;
      m_ack   = 2'b00;
      m_last  = 1;
   endtask

   task automatic check_regs(input string ctx);
      check({ctx, "_ack"},   ack,         m_ack);
      check({ctx, "_wr"},    fifo_wr,     m_pend);
      check({ctx, "_wdata"}, fifo_w_data, m_wdata);
      check({ctx, "_count"}, count,       m_q.size());
      check({ctx, "_af"},    almost_full, m_q.size() >= AF);
      check({ctx, "_full"},  full,        m_q.size() == DEPTH);
      check({ctx, "_empty"}, empty,       m_q.size() == 0);
   endtask

   // Entered just after a rising edge; returns one cycle later, just after the next edge.
   task automatic tick(input string ctx);
      bit           exp_rd;
      bit [1:0]     elig;
      bit           space;
      int           g;
      logic [B-1:0] popm;
      logic [B-1:0] popd;
      logic [B-1:0] gdata;
      bit           dwr;
      bit           drd;
      logic [B-1:0] dwd;
      popm = '0;
      @(negedge clk);
      exp_rd = rd_req && (m_q.size() != 0);
      check({ctx, "_rd"}, fifo_rd, exp_rd);
      dwr   = fifo_wr;
      dwd   = fifo_w_data;
      drd   = fifo_rd;
      elig  = req & ~m_ack;
      space = (m_q.size() + int'(m_pend)) < DEPTH;
      g     = -1;
      if (space) begin
         if (elig == 2'b11) g = (m_last == 0) ? 1 : 0;
         else if (elig[0]) g = 0;
         else if (elig[1]) g = 1;
      end
      gdata = (g == 1) ? data1 : data0;
      @(posedge clk);
      if (exp_rd) popm = m_q.pop_front();
      if (m_pend) m_q.push_back(m_wdata);
      if (drd) begin
         check({ctx, "_popnonempty"}, d_q.size() != 0, 1);
         if (d_q.size() != 0) begin
            popd = d_q.pop_front();
            if (exp_rd) check({ctx, "_rdata"}, popd, popm);
         end
      end
      if (dwr) d_q.push_back(dwd);
      m_ack  = 2'b00;
      m_pend = 1'b0;
      if (g >= 0) begin
         m_ack[g] = 1'b1;
         m_pend   = 1'b1;
         m_wdata  = gdata;
         m_last   = g;
      end
      #1;
      check_regs(ctx);
   endtask

   initial begin
      bit reached;
      model_reset();
      #12;
      check_regs("rst");
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Single requester: ack every second cycle.
      req   = 2'b01;
      data0 = 3'b101;
      tick("t1");
      check("t1_first_ack", ack, 2'b01);
      check("t1_first_wdata", fifo_w_data, 3'b101);
      repeat (5) tick("t1");
      req    = 2'b00;
      rd_req = 1'b1;
      repeat (5) tick("drain1");
      rd_req = 1'b0;

      // Two requesters alternate until the FIFO is full.
      req   = 2'b11;
      data0 = 3'b001;
      data1 = 3'b010;
      repeat (8) tick("t2");
      check("t2_full_count", count, 4);
      check("t2_full_flag", full, 1);

      // One read from full; the refill grant follows later.
      req    = 2'b10;
      rd_req = 1'b1;
      tick("t3rd");
      rd_req = 1'b0;
      repeat (4) tick("t3");
      check("t3_refill_count", count, 4);
      req    = 2'b00;
      rd_req = 1'b1;
      repeat (6) tick("drain2");

      // Reads on empty are dropped.
      repeat (3) tick("t4e");
      check("t4_empty_count", count, 0);
      rd_req = 1'b0;
      req    = 2'b01;
      data0  = 3'b110;
      tick("t4w");
      req = 2'b00;
      tick("t4w");
      rd_req = 1'b1;
      tick("t4r");
      rd_req = 1'b0;
      check("t4_after_read", count, 0);

      // Write issue coincides with a read at count 2.
      req     = 2'b01;
      data0   = 3'b011;
      reached = 1'b0;
      for (int i = 0; i < 20 && !reached; i++) begin
         tick("t5fill");
         reached = (m_q.size() == 2) && m_pend;
      end
      check("t5_reach", reached, 1);
      req    = 2'b00;
      rd_req = 1'b1;
      tick("t5rw");
      rd_req = 1'b0;
      check("t5_count_hold", count, 2);
      rd_req = 1'b1;
      repeat (4) tick("drain3");
      rd_req = 1'b0;

      // Asynchronous reset while a write is in flight at count 3.
      req     = 2'b11;
      data0   = 3'b100;
      data1   = 3'b111;
      reached = 1'b0;
      for (int i = 0; i < 20 && !reached; i++) begin
         tick("t6fill");
         reached = (m_q.size() == 3) && m_pend;
      end
      check("t6_reach", reached, 1);
      #1;
      reset = 1'b1;
      #1;
      check("t6_rst_count", count, 0);
      check("t6_rst_ack", ack, 2'b00);
      check("t6_rst_wr", fifo_wr, 0);
      model_reset();
      check_regs("t6rst");
      reset = 1'b0;
      tick("t6rr");
      check("t6_rr_first", ack, 2'b01);

      // Random traffic under the requester contract.
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 2; i++) begin
            if (req[i] && m_ack[i]) begin
               req[i] = 1'($urandom % 2);
               if (i == 0) data0 = 3'($urandom);
               else        data1 = 3'($urandom);
            end else if (!req[i]) begin
               if ($urandom % 3 == 0) begin
                  req[i] = 1'b1;
                  if (i == 0) data0 = 3'($urandom);
                  else        data1 = 3'($urandom);
               end
            end else if ($urandom % 16 == 0) begin
               req[i] = 1'b0;
            end
         end
         rd_req = (n < 200) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
         tick("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_port_sched.md
Name: fifo_port_sched

Overview:
- Owns both ports of one `fifo` instance (B-bit data, 2^W entries).
- Schedules writes from two independent requesters onto the single write port with round-robin fairness.
- Gates read requests so the FIFO is never popped when empty.
- Keeps a shadow occupancy count, used for full/almost-full decisions without a combinational path from the FIFO's `full` flag.

Parameters:
- B, 3, data word width; matches the FIFO's B.
- W, 2, FIFO address bits; DEPTH = 2^W entries.
- AF_LEVEL, 3, occupancy at or above which `almost_full` asserts; legal range 1..DEPTH.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req  in  2  per-requester write request; bit i belongs to requester i.
- data0  in  B  requester 0 write word; held stable while req[0]=1.
- data1  in  B  requester 1 write word; held stable while req[1]=1.
- ack  out  2  one-cycle pulse; ack[i]=1 in the cycle requester i's word is written.
- rd_req  in  1  consumer read request, e.g. a debounced button tick.
- fifo_wr  out  1  registered; drives FIFO `wr`.
- fifo_w_data  out  B  registered; drives FIFO `w_data`.
- fifo_rd  out  1  combinational; drives FIFO `rd`.
- count  out  W+1  shadow occupancy, 0..DEPTH.
- almost_full  out  1  registered; equals (count >= AF_LEVEL).
- full  out  1  equals (count == DEPTH).
- empty  out  1  equals (count == 0).

Behaviour:
- Reset values (async):
  - ack=0, fifo_wr=0, fifo_w_data=0, count=0, almost_full=0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
  - The FIFO shares this reset, so the shadow count stays coherent with it.
- Eligibility in cycle t: requester i is eligible when req[i]=1 and ack[i]=0. A requester is never granted in two consecutive cycles, which gives it one cycle to see ack and update data/req.
- Space check: a grant is allowed only when (count + fifo_wr) < DEPTH, where fifo_wr is the write in flight this cycle.
  - This is conservative: a same-cycle read does not create space.
- Arbitration when space is OK:
  - If one requester is eligible, grant it.
  - If both are eligible, grant the one with index != last.
  - On every grant, update last to the granted index.
- Grant issue at edge t→t+1:
  - fifo_wr=1, ack[g]=1, fifo_w_data=data_g (sampled in cycle t).
  - All of these are high for exactly one cycle per grant.
  - Latency from req to the write strobe is 1 cycle.
- No grant: fifo_wr=0, ack=0, fifo_w_data holds its last value, last is unchanged.
- Read gating: fifo_rd = rd_req & (count != 0). When count==0, rd_req is dropped and not remembered.
- Count update: count_next = count + fifo_wr − fifo_rd.
  - Simultaneous write and read leaves count unchanged.
  - count never exceeds DEPTH and never underflows; an assertion must flag either.
- Throughput:
  - A single requester gets at most one word every 2 cycles.
  - Two requesters can alternate and sustain 1 word/cycle.
- Reset mid-operation:
  - An in-flight fifo_wr is aborted; the FIFO clears on the same reset, so no word is lost silently.
  - A held req is re-arbitrated from requester 0 after reset.
- Requester contract: req[i] and data_i held until ack[i]; req may drop at any time before ack without side effects.

Test Plan:
- Reset, then req=2'b01 with data0=3'b101 held → ack[0] and fifo_wr in the cycle after req rises, fifo_w_data=101, count=1. With req held continuously, ack[0] repeats every second cycle.
- req=2'b11 held, data0=3'b001, data1=3'b010, no reads → acks alternate 01,10,01,10 on consecutive cycles. Writes stop at count=4 (DEPTH). almost_full=1 from count=3; full=1 at 4; FIFO r_data sequence is 001,010,001,010.
- FIFO full with req[1]=1, then a single rd_req pulse → fifo_rd=1, count drops 4→3. The grant comes on the next eligible cycle (not the read cycle's edge), and count returns to 4.
- count=0, rd_req=1 for 3 cycles → fifo_rd stays 0 and count stays 0. Then req[0] → write lands, the next rd_req gives fifo_rd=1 and count 1→0.
- Simultaneous write issue and rd_req at count=2 → count stays 2, no assertion fires.
- Assert reset during a fifo_wr=1 cycle with count=3 → outputs clear immediately, without waiting for a clock edge: count=0, ack=0, fifo_wr=0. After release with req=2'b11, requester 0 is granted first.
